// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: register address width, the x0 address,
// and the sequencer FSM state encoding (visible on state_o).
package riscv_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0_ADDR = 5'd0;

  typedef enum logic [1:0] {
    SEQ_RUN    = 2'b00,
    SEQ_DRAIN  = 2'b01,
    SEQ_HALTED = 2'b10,
    SEQ_STEP   = 2'b11
  } seq_state_e;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Bundle between the pipeline datapath (master) and the sequencer (slave):
// hazard/redirect/debug requests in, PC and pipeline-register controls out.
interface pipeline_sequencer_if
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
);

  logic [REG_ADDR_W-1:0] id_rs1_addr_i;
  logic [REG_ADDR_W-1:0] id_rs2_addr_i;
  logic                  ex_mem_read_en_i;
  logic [REG_ADDR_W-1:0] ex_rd_addr_i;
  logic                  ex_redirect_i;
  logic                  halt_req_i;
  logic                  step_req_i;
  logic                  resume_req_i;
  logic                  pc_write_en_o;
  logic                  if_id_write_en_o;
  logic                  if_id_flush_o;
  logic                  id_ex_flush_o;
  logic                  halted_o;
  logic [1:0]            state_o;
  logic [CNT_W-1:0]      stall_count_o;
  logic [CNT_W-1:0]      flush_count_o;

  modport master (
    output id_rs1_addr_i, id_rs2_addr_i, ex_mem_read_en_i, ex_rd_addr_i,
           ex_redirect_i, halt_req_i, step_req_i, resume_req_i,
    input  pc_write_en_o, if_id_write_en_o, if_id_flush_o, id_ex_flush_o,
           halted_o, state_o, stall_count_o, flush_count_o
  );

  modport slave (
    input  id_rs1_addr_i, id_rs2_addr_i, ex_mem_read_en_i, ex_rd_addr_i,
           ex_redirect_i, halt_req_i, step_req_i, resume_req_i,
    output pc_write_en_o, if_id_write_en_o, if_id_flush_o, id_ex_flush_o,
           halted_o, state_o, stall_count_o, flush_count_o
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detect: a load in EX whose rd (not x0)
// is a source of the instruction currently in ID.
module load_use_detect
  import riscv_pkg::*;
(
  input  logic                  ex_mem_read_en,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  output logic                  load_use
);

  assign load_use = ex_mem_read_en
                  & (ex_rd_addr != X0_ADDR)
                  & ((ex_rd_addr == id_rs1_addr) | (ex_rd_addr == id_rs2_addr));

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: load-use stalls, EX redirect flushes and the debug
// halt/step/resume FSM. Define PIPE_PERF_COUNTERS_EN for stall/flush counters.
module pipeline_sequencer
  import riscv_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input logic clk_i,
  input logic rst_i,
  pipeline_sequencer_if.slave bus
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  seq_state_e         state_r, state_nxt_s;
  logic [DRAIN_W-1:0] drain_cnt_r, drain_cnt_nxt_s;
  logic               load_use_s, redirect_s, stall_s;
  logic               pc_we_s, if_id_we_s, if_id_flush_s, id_ex_flush_s;

  load_use_detect u_load_use_detect (
    .ex_mem_read_en (bus.ex_mem_read_en_i),
    .ex_rd_addr     (bus.ex_rd_addr_i),
    .id_rs1_addr    (bus.id_rs1_addr_i),
    .id_rs2_addr    (bus.id_rs2_addr_i),
    .load_use       (load_use_s)
  );

  // A redirect squashes ID, so a simultaneous load-use never stalls.
  assign redirect_s = bus.ex_redirect_i;
  assign stall_s    = load_use_s & ~redirect_s;

  // FSM state and drain counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= SEQ_RUN;
      drain_cnt_r <= {DRAIN_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      drain_cnt_r <= drain_cnt_nxt_s;
    end
  end

  // Next-state and per-cycle pipeline control
  always_comb begin
    state_nxt_s     = state_r;
    drain_cnt_nxt_s = drain_cnt_r;
    pc_we_s         = 1'b0;
    if_id_we_s      = 1'b0;
    if_id_flush_s   = 1'b1;
    id_ex_flush_s   = 1'b1;
    case (state_r)
      SEQ_RUN: begin
        if (bus.halt_req_i && !stall_s) begin
          // Halt acceptance cycle already behaves as the first drain cycle.
          state_nxt_s     = SEQ_DRAIN;
          drain_cnt_nxt_s = DRAIN_LOAD;
          pc_we_s         = redirect_s;
          if_id_we_s      = 1'b0;
          if_id_flush_s   = 1'b1;
          id_ex_flush_s   = redirect_s;
        end else if (redirect_s) begin
          pc_we_s       = 1'b1;
          if_id_we_s    = 1'b1;
          if_id_flush_s = 1'b1;
          id_ex_flush_s = 1'b1;
        end else if (load_use_s) begin
          pc_we_s       = 1'b0;
          if_id_we_s    = 1'b0;
          if_id_flush_s = 1'b0;
          id_ex_flush_s = 1'b1;
        end else begin
          pc_we_s       = 1'b1;
          if_id_we_s    = 1'b1;
          if_id_flush_s = 1'b0;
          id_ex_flush_s = 1'b0;
        end
      end
      SEQ_DRAIN: begin
        pc_we_s       = redirect_s;
        if_id_we_s    = 1'b0;
        if_id_flush_s = 1'b1;
        id_ex_flush_s = redirect_s;
        if (stall_s) begin
          if_id_flush_s = 1'b0;
          id_ex_flush_s = 1'b1;
        end else if (drain_cnt_r == {DRAIN_W{1'b0}}) begin
          state_nxt_s = SEQ_HALTED;
        end else begin
          drain_cnt_nxt_s = drain_cnt_r - DRAIN_W'(1);
        end
      end
      SEQ_HALTED: begin
        if (bus.resume_req_i) begin
          state_nxt_s = SEQ_RUN;
        end else if (bus.step_req_i) begin
          state_nxt_s = SEQ_STEP;
        end else begin
          state_nxt_s = SEQ_HALTED;
        end
      end
      SEQ_STEP: begin
        pc_we_s         = 1'b1;
        if_id_we_s      = 1'b1;
        if_id_flush_s   = 1'b0;
        id_ex_flush_s   = 1'b0;
        state_nxt_s     = SEQ_DRAIN;
        drain_cnt_nxt_s = DRAIN_LOAD;
      end
      default: begin
        state_nxt_s     = SEQ_RUN;
        drain_cnt_nxt_s = {DRAIN_W{1'b0}};
      end
    endcase
  end

  // Reset overrides the control outputs combinationally (freeze + flush).
  assign bus.pc_write_en_o    = ~rst_i & pc_we_s;
  assign bus.if_id_write_en_o = ~rst_i & if_id_we_s;
  assign bus.if_id_flush_o    = rst_i | if_id_flush_s;
  assign bus.id_ex_flush_o    = rst_i | id_ex_flush_s;
  assign bus.halted_o         = ~rst_i & (state_r == SEQ_HALTED);
  assign bus.state_o          = state_r;

`ifdef PIPE_PERF_COUNTERS_EN
  logic             active_s;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  assign active_s = (state_r == SEQ_RUN) | (state_r == SEQ_DRAIN);

  // Wrapping performance counters, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (active_s && stall_s) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (active_s && redirect_s) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end
    end
  end

  assign bus.stall_count_o = stall_cnt_r;
  assign bus.flush_count_o = flush_cnt_r;
`else
  assign bus.stall_count_o = {CNT_W{1'b0}};
  assign bus.flush_count_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios then random
// stimulus, compared cycle by cycle against a mode-level behavioural model.
module tb_pipeline_sequencer;

  localparam int DRAIN_CYCLES = 4;
  localparam int CNT_W        = 32;
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2, M_STEP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_sequencer_if #(.CNT_W(CNT_W)) bus();

  pipeline_sequencer #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  int               m_state = M_RUN;
  int               m_left  = 0;
  bit               m_known = 1'b0;
  bit               saw_halt = 1'b0;
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_flush = '0;

  task automatic check(input string tag, input logic [CNT_W-1:0] got, input logic [CNT_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input bit rd_en, input int ex_rd, input int rs1, input int rs2,
                       input bit redir, input bit halt, input bit step, input bit resume,
                       input bit reset);
    bit lu, stall, e_pc, e_we, e_we_care, e_iff, e_idf, e_halt;
    int n_state, n_left;
    logic [CNT_W-1:0] e_sc, e_fc;
    @(negedge clk);
    rst                  = reset;
    bus.ex_mem_read_en_i = rd_en;
    bus.ex_rd_addr_i     = 5'(ex_rd);
    bus.id_rs1_addr_i    = 5'(rs1);
    bus.id_rs2_addr_i    = 5'(rs2);
    bus.ex_redirect_i    = redir;
    bus.halt_req_i       = halt;
    bus.step_req_i       = step;
    bus.resume_req_i     = resume;
    #1;
    lu        = rd_en && (ex_rd != 0) && ((ex_rd == rs1) || (ex_rd == rs2));
    stall     = lu && !redir;
    n_state   = m_state;
    n_left    = m_left;
    e_we_care = 1'b1;
    e_halt    = 1'b0;
    e_pc = 1'b0; e_we = 1'b0; e_iff = 1'b1; e_idf = 1'b1;
    if (reset) begin
      n_state = M_RUN;
      n_left  = 0;
    end else begin
      case (m_state)
        M_RUN: begin
          if (halt && !stall) begin
            e_pc = redir; e_iff = 1'b1; e_idf = redir; e_we_care = 1'b0;
            n_state = M_DRAIN;
            n_left  = DRAIN_CYCLES;
          end else if (redir) begin
            e_pc = 1'b1; e_we = 1'b1; e_iff = 1'b1; e_idf = 1'b1;
          end else if (lu) begin
            e_pc = 1'b0; e_we = 1'b0; e_iff = 1'b0; e_idf = 1'b1;
          end else begin
            e_pc = 1'b1; e_we = 1'b1; e_iff = 1'b0; e_idf = 1'b0;
          end
        end
        M_DRAIN: begin
          e_pc  = redir;
          e_iff = !stall;
          e_idf = redir || stall;
          e_we_care = stall;
          e_we  = 1'b0;
          if (!stall) begin
            n_left = m_left - 1;
            if (n_left == 0) n_state = M_HALTED;
          end
        end
        M_HALTED: begin
          e_halt = 1'b1;
          if (resume) n_state = M_RUN;
          else if (step) n_state = M_STEP;
        end
        M_STEP: begin
          e_pc = 1'b1; e_we = 1'b1; e_iff = 1'b0; e_idf = 1'b0;
          n_state = M_DRAIN;
          n_left  = DRAIN_CYCLES;
        end
        default: n_state = M_RUN;
      endcase
    end
`ifdef PIPE_PERF_COUNTERS_EN
    e_sc = m_stall;
    e_fc = m_flush;
`else
    e_sc = '0;
    e_fc = '0;
`endif
    check("pc_write_en", bus.pc_write_en_o, e_pc);
    if (e_we_care) check("if_id_write_en", bus.if_id_write_en_o, e_we);
    check("if_id_flush", bus.if_id_flush_o, e_iff);
    check("id_ex_flush", bus.id_ex_flush_o, e_idf);
    check("halted", bus.halted_o, reset ? 1'b0 : e_halt);
    if (m_known) begin
      check("state", bus.state_o, m_state);
      check("stall_count", bus.stall_count_o, e_sc);
      check("flush_count", bus.flush_count_o, e_fc);
    end
    if (bus.halted_o === 1'b1) saw_halt = 1'b1;
    @(posedge clk);
    if (reset) begin
      m_stall = '0;
      m_flush = '0;
      m_known = 1'b1;
    end else if (m_state == M_RUN || m_state == M_DRAIN) begin
      if (stall) m_stall = m_stall + 1;
      if (redir) m_flush = m_flush + 1;
    end
    m_state = n_state;
    m_left  = n_left;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit halt_lvl, rd_en, redir;
    bus.ex_mem_read_en_i = 1'b0; bus.ex_rd_addr_i = 5'd0;
    bus.id_rs1_addr_i = 5'd0; bus.id_rs2_addr_i = 5'd0;
    bus.ex_redirect_i = 1'b0; bus.halt_req_i = 1'b0;
    bus.step_req_i = 1'b0; bus.resume_req_i = 1'b0;

    cycle(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    // load-use on rs1, then x0 load exemption, then redirect beating load-use
    cycle(1'b1, 5, 5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    cycle(1'b1, 0, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 5, 5, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    // halt pulse, redirect mid-drain, reach HALTED
    cycle(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    cycle(1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    // single step, drain back to HALTED, then resume+step together
    cycle(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(6);
    cycle(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    // reset in the middle of a drain
    cycle(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    cycle(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    halt_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rd_en = ($urandom % 3) == 0;
      redir = ($urandom % 6) == 0;
      if (m_state == M_HALTED || m_state == M_STEP) begin
        rd_en = 1'b0;
        redir = 1'b0;
      end
      if (($urandom % 15) == 0) halt_lvl = !halt_lvl;
      cycle(rd_en, int'($urandom % 4), int'($urandom % 4), int'($urandom % 4), redir,
            halt_lvl, ($urandom % 4) == 0, ($urandom % 6) == 0, ($urandom % 250) == 0);
    end

    check("reached_halted", saw_halt, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
